// File: rtl/mm_bridge_pkg.sv
// Shared definitions for the modexp MMIO bridge: register map, bit positions, operand selects, FSM states.
package mm_bridge_pkg;

    localparam int unsigned OFF_W = 5;

    localparam logic [OFF_W-1:0] OFF_CTRL   = 5'h00;
    localparam logic [OFF_W-1:0] OFF_CFG    = 5'h02;
    localparam logic [OFF_W-1:0] OFF_A      = 5'h04;
    localparam logic [OFF_W-1:0] OFF_B      = 5'h06;
    localparam logic [OFF_W-1:0] OFF_M      = 5'h08;
    localparam logic [OFF_W-1:0] OFF_M0     = 5'h0A;
    localparam logic [OFF_W-1:0] OFF_RPTR   = 5'h0C;
    localparam logic [OFF_W-1:0] OFF_RESULT = 5'h0E;
    localparam logic [OFF_W-1:0] OFF_STATUS = 5'h10;

    localparam int unsigned CTRL_SRST    = 0;
    localparam int unsigned CTRL_START   = 1;
    localparam int unsigned CTRL_AUTOINC = 2;
    localparam int unsigned CTRL_IE      = 3;

    localparam int unsigned ST_BUSY = 0;
    localparam int unsigned ST_DONE = 1;
    localparam int unsigned ST_ERR  = 2;

    localparam int unsigned E_W       = 8;
    localparam int unsigned CFG_E_LSB = 8;

    localparam logic [1:0] OP_SEL_A = 2'd0;
    localparam logic [1:0] OP_SEL_B = 2'd1;
    localparam logic [1:0] OP_SEL_M = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mm_bridge_decode.sv
// Window hit detection and halfword-aligned register offset extraction (combinational).
module mm_bridge_decode
    import mm_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_W   = 42,
    parameter logic [ADDR_W-1:0]     BASEADDR = 42'h0,
    parameter logic [ADDR_W-1:0]     HIGHADDR = 42'h1F
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit_c,
    output logic [OFF_W-1:0]  off_c
);

    logic [ADDR_W-1:0] diff;

    // Offsets beyond the 32-byte register map never hit, even if the window is larger.
    always_comb begin
        diff  = addr - BASEADDR;
        hit_c = (addr >= BASEADDR) && (addr <= HIGHADDR) && (diff[ADDR_W-1:OFF_W] == '0);
        off_c = diff[OFF_W-1:0] & 5'h1E;
    end

endmodule

// File: rtl/mm_bridge_p.sv
// MMIO bridge onto the Montgomery/modexp core: operand load, config, start/done handshake, result readout.
// Optional interrupt output enabled by defining MM_BRIDGE_IRQ_EN.
module mm_bridge_p
    import mm_bridge_pkg::*;
#(
    parameter int unsigned           ADDR_W             = 42,
    parameter logic [ADDR_W-1:0]     MM_BRIDGE_BASEADDR = 42'h0,
    parameter logic [ADDR_W-1:0]     MM_BRIDGE_HIGHADDR = 42'h1F,
    parameter int unsigned           DW                 = 16,
    parameter int unsigned           NWORDS             = 16,
    localparam int unsigned          PW                 = $clog2(NWORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              read,
    input  logic              write,
    input  logic [DW-1:0]     din,
    output logic [DW-1:0]     dout,
    output logic              core_rst,
    output logic              core_start,
    input  logic              core_done,
    output logic [E_W-1:0]    core_e,
    output logic [DW-1:0]     core_m0,
    output logic              op_we,
    output logic [1:0]        op_sel,
    output logic [PW-1:0]     op_idx,
    output logic [DW-1:0]     op_data,
    output logic [PW-1:0]     res_idx,
    input  logic [DW-1:0]     res_data
`ifdef MM_BRIDGE_IRQ_EN
    ,
    output logic              irq
`endif
);

    logic             hit;
    logic [OFF_W-1:0] off;

    mm_bridge_decode #(
        .ADDR_W   (ADDR_W),
        .BASEADDR (MM_BRIDGE_BASEADDR),
        .HIGHADDR (MM_BRIDGE_HIGHADDR)
    ) u_decode (
        .addr  (addr),
        .hit_c (hit),
        .off_c (off)
    );

    state_t         state_q, state_d;
    logic           srst_q, srst_d;
    logic           core_rst_q, core_rst_d;
    logic           autoinc_q, autoinc_d;
    logic [E_W-1:0] e_q, e_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [DW-1:0]  m0_q, m0_d;
    logic           err_q, err_d;
    logic [DW-1:0]  dout_q, dout_d;
    logic           start_q, start_d;
    logic           op_we_q, op_we_d;
    logic [1:0]     op_sel_q, op_sel_d;
    logic [PW-1:0]  op_idx_q, op_idx_d;
    logic [DW-1:0]  op_data_q, op_data_d;
    logic [DW-1:0]  rd_val;
    logic           is_run;
`ifdef MM_BRIDGE_IRQ_EN
    logic           ie_q, ie_d;
    logic           irq_q, irq_d;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NWORDS - 1)) ? '0 : p + PW'(1);
    endfunction

    // Register state update; core_rst comes out of reset asserted until CTRL is written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            srst_q     <= 1'b0;
            core_rst_q <= 1'b1;
            autoinc_q  <= 1'b0;
            e_q        <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            m0_q       <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
            start_q    <= 1'b0;
            op_we_q    <= 1'b0;
            op_sel_q   <= '0;
            op_idx_q   <= '0;
            op_data_q  <= '0;
`ifdef MM_BRIDGE_IRQ_EN
            ie_q       <= 1'b0;
            irq_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            srst_q     <= srst_d;
            core_rst_q <= core_rst_d;
            autoinc_q  <= autoinc_d;
            e_q        <= e_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            m0_q       <= m0_d;
            err_q      <= err_d;
            dout_q     <= dout_d;
            start_q    <= start_d;
            op_we_q    <= op_we_d;
            op_sel_q   <= op_sel_d;
            op_idx_q   <= op_idx_d;
            op_data_q  <= op_data_d;
`ifdef MM_BRIDGE_IRQ_EN
            ie_q       <= ie_d;
            irq_q      <= irq_d;
`endif
        end
    end

    // Next-state: read mux, bus writes, FSM transitions, RUN lockout and soft-reset override.
    always_comb begin
        state_d    = state_q;
        srst_d     = srst_q;
        core_rst_d = core_rst_q;
        autoinc_d  = autoinc_q;
        e_d        = e_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        m0_d       = m0_q;
        err_d      = err_q;
        dout_d     = '0;
        start_d    = 1'b0;
        op_we_d    = 1'b0;
        op_sel_d   = op_sel_q;
        op_idx_d   = op_idx_q;
        op_data_d  = op_data_q;
        rd_val     = '0;
        is_run     = (state_q == S_RUN);
`ifdef MM_BRIDGE_IRQ_EN
        ie_d       = ie_q;
`endif

        // Read path uses current register values, so a same-cycle write is seen only afterwards.
        case (off)
            OFF_CTRL: begin
                rd_val[CTRL_SRST]    = srst_q;
                rd_val[CTRL_AUTOINC] = autoinc_q;
`ifdef MM_BRIDGE_IRQ_EN
                rd_val[CTRL_IE]      = ie_q;
`endif
            end
            OFF_CFG: begin
                rd_val[CFG_E_LSB +: E_W] = e_q;
                rd_val[PW-1:0]           = wptr_q;
            end
            OFF_M0:     rd_val = m0_q;
            OFF_RPTR:   rd_val[PW-1:0] = rptr_q;
            OFF_RESULT: rd_val = res_data;
            OFF_STATUS: begin
                rd_val[ST_BUSY] = is_run;
                rd_val[ST_DONE] = (state_q == S_DONE);
                rd_val[ST_ERR]  = err_q;
            end
            default:    rd_val = '0;
        endcase

        if (read && hit) begin
            dout_d = rd_val;
            if (off == OFF_RESULT && autoinc_q) begin
                rptr_d = ptr_inc(rptr_q);
            end
        end

        if (is_run && core_done) begin
            state_d = S_DONE;
        end

        if (write && hit) begin
            case (off)
                OFF_CTRL: begin
                    srst_d     = din[CTRL_SRST];
                    core_rst_d = din[CTRL_SRST];
                    autoinc_d  = din[CTRL_AUTOINC];
`ifdef MM_BRIDGE_IRQ_EN
                    ie_d       = din[CTRL_IE];
`endif
                    if (din[CTRL_START] && !din[CTRL_SRST]) begin
                        if (is_run) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = S_RUN;
                            start_d = 1'b1;
                        end
                    end
                end
                OFF_CFG: begin
                    if (is_run) begin
                        err_d = 1'b1;
                    end else begin
                        e_d    = din[CFG_E_LSB +: E_W];
                        wptr_d = din[PW-1:0];
                    end
                end
                OFF_A, OFF_B, OFF_M: begin
                    if (is_run) begin
                        err_d = 1'b1;
                    end else begin
                        op_we_d   = 1'b1;
                        op_idx_d  = wptr_q;
                        op_data_d = din;
                        op_sel_d  = (off == OFF_A) ? OP_SEL_A :
                                    (off == OFF_B) ? OP_SEL_B : OP_SEL_M;
                        // Pointer advances once per A/B/M triple, on the M word.
                        if (off == OFF_M && autoinc_q) begin
                            wptr_d = ptr_inc(wptr_q);
                        end
                    end
                end
                OFF_M0: begin
                    if (is_run) begin
                        err_d = 1'b1;
                    end else begin
                        m0_d = din;
                    end
                end
                OFF_RPTR: rptr_d = din[PW-1:0];
                OFF_STATUS: begin
                    if (din[ST_ERR]) begin
                        err_d = 1'b0;
                    end
                    if (din[ST_DONE] && state_q == S_DONE) begin
                        state_d = S_IDLE;
                    end
                end
                default: ;
            endcase
        end

        // Soft reset aborts any run and holds pointers and status clear.
        if (srst_d) begin
            state_d = S_IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            err_d   = 1'b0;
            start_d = 1'b0;
        end

`ifdef MM_BRIDGE_IRQ_EN
        irq_d = (state_d == S_DONE) && ie_d;
`endif
    end

    assign dout       = dout_q;
    assign core_rst   = core_rst_q;
    assign core_start = start_q;
    assign core_e     = e_q;
    assign core_m0    = m0_q;
    assign op_we      = op_we_q;
    assign op_sel     = op_sel_q;
    assign op_idx     = op_idx_q;
    assign op_data    = op_data_q;
    assign res_idx    = rptr_q;
`ifdef MM_BRIDGE_IRQ_EN
    assign irq        = irq_q;
`endif

endmodule

// File: tb/tb_mm_bridge_p.sv
// Scoreboard bench for mm_bridge_p: read and operand-write expectations queued at stimulus, checked at output.
module tb_mm_bridge_p;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [41:0] addr = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] dout;
    logic        core_rst;
    logic        core_start;
    logic        core_done = 1'b0;
    logic [7:0]  core_e;
    logic [15:0] core_m0;
    logic        op_we;
    logic [1:0]  op_sel;
    logic [3:0]  op_idx;
    logic [15:0] op_data;
    logic [3:0]  res_idx;
    logic [15:0] res_data;
`ifdef MM_BRIDGE_IRQ_EN
    logic        irq;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_op    = 0;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_q[$];
    logic [21:0] op_q[$];

    always #5 clk = ~clk;

    assign res_data = 16'h0100 + 16'(res_idx);

    mm_bridge_p dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .read       (read),
        .write      (write),
        .din        (din),
        .dout       (dout),
        .core_rst   (core_rst),
        .core_start (core_start),
        .core_done  (core_done),
        .core_e     (core_e),
        .core_m0    (core_m0),
        .op_we      (op_we),
        .op_sel     (op_sel),
        .op_idx     (op_idx),
        .op_data    (op_data),
        .res_idx    (res_idx),
        .res_data   (res_data)
`ifdef MM_BRIDGE_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) rd_pend <= read;

    // Output side of the scoreboard: pop on read data and operand strobes.
    always @(negedge clk) begin
        if (rst_n && rd_pend) begin
            if (rd_q.size() == 0) chk("rd_underflow", 32'(rd_q.size()), 1);
            else chk("dout", 32'(dout), 32'(rd_q.pop_front()));
        end
        if (rst_n && core_start) n_start++;
        if (rst_n && op_we) begin
            n_op++;
            if (op_q.size() == 0) chk("op_unexpected", 32'({op_sel, op_idx, op_data}), 0);
            else chk("op_write", 32'({op_sel, op_idx, op_data}), 32'(op_q.pop_front()));
        end
    end

    task automatic bus_write(input logic [41:0] a, input logic [15:0] d);
        @(negedge clk);
        addr = a; din = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [41:0] a, input logic [15:0] exp);
        @(negedge clk);
        addr = a; read = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        read = 1'b0;
    endtask

    task automatic bus_rw(input logic [41:0] a, input logic [15:0] d, input logic [15:0] exp);
        @(negedge clk);
        addr = a; din = d; read = 1'b1; write = 1'b1;
        rd_q.push_back(exp);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
    endtask

    task automatic pulse_done();
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset state
        repeat (3) @(negedge clk);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_core_rst", 32'(core_rst), 1);
        chk("rst_core_start", 32'(core_start), 0);
        chk("rst_op_we", 32'(op_we), 0);
        rst_n = 1'b1;
        bus_read(42'h10, 16'h0000);
        chk("core_rst_held", 32'(core_rst), 1);
        bus_write(42'h00, 16'h0000);
        chk("core_rst_release", 32'(core_rst), 0);

        // 2: operand load with autoinc; pointer moves only on M, wraps after 16
        bus_write(42'h00, 16'h0004);
        bus_write(42'h02, 16'h0300);
        chk("core_e", 32'(core_e), 3);
        for (int i = 0; i < 16; i++) begin
            op_q.push_back({2'd0, 4'(i), 16'd2191});
            bus_write(42'h04, 16'd2191);
            op_q.push_back({2'd1, 4'(i), 16'd1337});
            bus_write(42'h06, 16'd1337);
            op_q.push_back({2'd2, 4'(i), 16'd3317});
            bus_write(42'h08, 16'd3317);
        end
        idle(1);
        chk("op_count", 32'(n_op), 48);
        bus_read(42'h02, 16'h0300);
        bus_write(42'h0A, 16'h1234);
        chk("core_m0", 32'(core_m0), 32'h1234);
        bus_read(42'h0A, 16'h1234);
        bus_read(42'h20, 16'h0000);
        bus_read(42'h14, 16'h0000);
        bus_read(42'h11, 16'h0000);

        // 3: start / done / W1C
        bus_write(42'h00, 16'h0006);
        idle(2);
        chk("start_pulses_1", 32'(n_start), 1);
        bus_read(42'h10, 16'h0001);
        idle(3);
        pulse_done();
        bus_read(42'h10, 16'h0002);
        bus_write(42'h10, 16'h0002);
        bus_read(42'h10, 16'h0000);

        // 4: lockout during RUN, err sticky, start+done collision
        bus_write(42'h00, 16'h0006);
        bus_read(42'h10, 16'h0001);
        bus_write(42'h04, 16'hDEAD);
        bus_write(42'h0A, 16'hBEEF);
        bus_read(42'h10, 16'h0005);
        chk("m0_locked", 32'(core_m0), 32'h1234);
        bus_write(42'h10, 16'h0004);
        bus_read(42'h10, 16'h0001);
        @(negedge clk);
        addr = 42'h00; din = 16'h0006; write = 1'b1; core_done = 1'b1;
        @(negedge clk);
        write = 1'b0; core_done = 1'b0;
        bus_read(42'h10, 16'h0006);
        chk("start_pulses_2", 32'(n_start), 2);
        bus_write(42'h10, 16'h0006);
        bus_read(42'h10, 16'h0000);
        pulse_done();
        bus_read(42'h10, 16'h0000);

        // 5: result readout with autoinc and wrap; read+write same cycle
        bus_write(42'h0C, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            bus_read(42'h0E, 16'h0100 + 16'(i));
        end
        bus_read(42'h0C, 16'h0000);
        chk("res_idx_wrap", 32'(res_idx), 0);
        bus_rw(42'h0A, 16'h5555, 16'h1234);
        bus_read(42'h0A, 16'h5555);

        // 6: soft reset mid-RUN
        bus_write(42'h00, 16'h0006);
        bus_read(42'h10, 16'h0001);
        bus_write(42'h00, 16'h0001);
        chk("srst_core_rst", 32'(core_rst), 1);
        bus_read(42'h10, 16'h0000);
        pulse_done();
        bus_read(42'h10, 16'h0000);
        bus_read(42'h02, 16'h0300);
        bus_read(42'h0A, 16'h5555);
`ifdef MM_BRIDGE_IRQ_EN
        chk("irq_srst", 32'(irq), 0);
`endif
        bus_write(42'h00, 16'h0000);
        chk("srst_release", 32'(core_rst), 0);
        chk("start_pulses_3", 32'(n_start), 3);

`ifdef MM_BRIDGE_IRQ_EN
        // irq follows done when enabled, clears with W1C
        bus_write(42'h00, 16'h000A);
        pulse_done();
        idle(1);
        chk("irq_set", 32'(irq), 1);
        bus_write(42'h10, 16'h0002);
        idle(1);
        chk("irq_clear", 32'(irq), 0);
`endif

        idle(2);
        chk("rd_q_drained", 32'(rd_q.size()), 0);
        chk("op_q_drained", 32'(op_q.size()), 0);
        chk("op_count_final", 32'(n_op), 48);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
